// File: rtl/sbp_pkg.sv
// Shared widths, derived result layout and head-bundle type for the
// scalable-pipelined lookup chain.
package sbp_pkg;

  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int PAD_BITS      = 4;
  localparam int LR_BITS       = 1;

  // Each result field is padded up to a whole nibble so the word reads cleanly in hex.
  localparam int STAGE_PAD    = (PAD_BITS - (STAGE_ID_BITS % PAD_BITS)) % PAD_BITS;
  localparam int LOCATION_PAD = (PAD_BITS - (LOCATION_BITS % PAD_BITS)) % PAD_BITS;
  localparam int LR_PAD       = (PAD_BITS - (LR_BITS % PAD_BITS)) % PAD_BITS;
  localparam int RESULT_BITS  = STAGE_ID_BITS + STAGE_PAD + LOCATION_BITS + LOCATION_PAD
                              + LR_BITS + LR_PAD;

  // Stage id 0 is never a real stage, so it doubles as the bubble marker.
  localparam logic [STAGE_ID_BITS-1:0] ROOT_STAGE_ID = STAGE_ID_BITS'(1);

  typedef struct packed {
    logic                     update;
    logic [31:0]              ip_addr;
    logic [5:0]               bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } sbp_head_t;

endpackage

// File: rtl/sbp_tag_delay.sv
// Valid+tag delay line that follows each lookup down the stage chain so the
// tail result can be matched with the tag of the lookup that produced it.
module sbp_tag_delay #(
  parameter int DEPTH    = 48,
  parameter int TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic                valid_i,
  input  logic [TAG_BITS-1:0] tag_i,
  output logic                valid_o,
  output logic [TAG_BITS-1:0] tag_o
);

  logic [DEPTH-1:0]               valid_q, valid_d;
  logic [DEPTH-1:0][TAG_BITS-1:0] tag_q, tag_d;

  // Shift every entry one slot toward the tail and load the new entry at slot 0.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    valid_d[0] = valid_i;
    tag_d[0]   = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
  end

  // Synchronous clear drops everything in flight.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/sbp_pipeline_scheduler.sv
// Head-of-pipeline scheduler: arbitrates lookups against table updates,
// injects at most one operation per cycle and returns tagged lookup results.
module sbp_pipeline_scheduler
  import sbp_pkg::*;
#(
  parameter int NUM_STAGES    = 24,
  parameter int PIPE_LATENCY  = 2 * NUM_STAGES,
  parameter int TAG_BITS      = 8,
  parameter int MAX_UPD_BURST = 4,
  localparam int INFLIGHT_BITS = $clog2(PIPE_LATENCY + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [31:0]              lkp_ip_addr_i,
  input  logic [TAG_BITS-1:0]      lkp_tag_i,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [31:0]              upd_prefix_i,
  input  logic [5:0]               upd_len_i,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] upd_location_i,
  input  logic [RESULT_BITS-1:0]   upd_result_i,
  input  logic                     upd_sync_i,
  output logic                     update_o,
  output logic [31:0]              ip_addr_o,
  output logic [5:0]               bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,
  input  logic [RESULT_BITS-1:0]   tail_result_i,
  output logic                     res_valid_o,
  output logic [TAG_BITS-1:0]      res_tag_o,
  output logic [RESULT_BITS-1:0]   res_result_o,
  output logic [INFLIGHT_BITS-1:0] inflight_o,
  output logic                     busy_o
);

  localparam int BURST_BITS = $clog2(MAX_UPD_BURST + 1);
  localparam logic [BURST_BITS-1:0] BURST_MAX = BURST_BITS'(MAX_UPD_BURST);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [BURST_BITS-1:0]    burst_q, burst_d;
  logic [INFLIGHT_BITS-1:0] inflight_q, inflight_d;
  sbp_head_t                head_q, head_d;
  logic                     res_valid_q, res_valid_d;
  logic [TAG_BITS-1:0]      res_tag_q, res_tag_d;
  logic [RESULT_BITS-1:0]   res_result_q, res_result_d;

  logic                     sync_blocked;
  logic                     lkp_turn;
  logic                     lkp_grant;
  logic                     upd_grant;
  logic                     tail_valid;
  logic [TAG_BITS-1:0]      tail_tag;

  // A barrier update may not enter while lookups are still in the chain, and a
  // saturated update burst hands one slot to a waiting lookup.
  assign sync_blocked = upd_valid_i && upd_sync_i && (inflight_q != '0);
  assign lkp_turn     = upd_valid_i && lkp_valid_i && (burst_q == BURST_MAX);

  // Arbitration: readies come straight from state and requests; DRAIN holds both off.
  always_comb begin
    state_d     = state_q;
    lkp_ready_o = 1'b0;
    upd_ready_o = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (sync_blocked) begin
          state_d = ST_DRAIN;
        end else if (upd_valid_i && !lkp_turn) begin
          upd_ready_o = 1'b1;
        end else begin
          lkp_ready_o = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!upd_valid_i || (inflight_q == '0)) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign lkp_grant = lkp_valid_i && lkp_ready_o;
  assign upd_grant = upd_valid_i && upd_ready_o;

  // Next head bundle, burst counter, in-flight count and returned result.
  always_comb begin
    head_d          = head_q;
    head_d.update   = 1'b0;
    head_d.stage_id = '0;
    if (upd_grant) begin
      head_d.update   = 1'b1;
      head_d.ip_addr  = upd_prefix_i;
      head_d.bit_pos  = upd_len_i;
      head_d.stage_id = upd_stage_id_i;
      head_d.location = upd_location_i;
      head_d.result   = upd_result_i;
    end else if (lkp_grant) begin
      head_d.ip_addr  = lkp_ip_addr_i;
      head_d.bit_pos  = 6'd0;
      head_d.stage_id = ROOT_STAGE_ID;
      head_d.location = '0;
      head_d.result   = '0;
    end

    burst_d = '0;
    if (upd_grant) begin
      burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_BITS'(1);
    end

    inflight_d = inflight_q;
    if (lkp_grant && !tail_valid) begin
      inflight_d = inflight_q + INFLIGHT_BITS'(1);
    end else if (!lkp_grant && tail_valid) begin
      inflight_d = inflight_q - INFLIGHT_BITS'(1);
    end

    res_valid_d  = tail_valid;
    res_tag_d    = tail_valid ? tail_tag : res_tag_q;
    res_result_d = tail_valid ? tail_result_i : res_result_q;
  end

  // All scheduler state, including the FSM, registers here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      burst_q      <= '0;
      inflight_q   <= '0;
      head_q       <= '0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_result_q <= '0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      res_valid_q  <= res_valid_d;
      res_tag_q    <= res_tag_d;
      res_result_q <= res_result_d;
    end
  end

  sbp_tag_delay #(
    .DEPTH    (PIPE_LATENCY),
    .TAG_BITS (TAG_BITS)
  ) u_tag_delay (
    .clk     (clk),
    .clr_i   (rst),
    .valid_i (lkp_grant),
    .tag_i   (lkp_tag_i),
    .valid_o (tail_valid),
    .tag_o   (tail_tag)
  );

  assign update_o     = head_q.update;
  assign ip_addr_o    = head_q.ip_addr;
  assign bit_pos_o    = head_q.bit_pos;
  assign stage_id_o   = head_q.stage_id;
  assign location_o   = head_q.location;
  assign result_o     = head_q.result;
  assign res_valid_o  = res_valid_q;
  assign res_tag_o    = res_tag_q;
  assign res_result_o = res_result_q;
  assign inflight_o   = inflight_q;
  assign busy_o       = (inflight_q != '0) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_sbp_pipeline_scheduler.sv
// Bench for the pipeline scheduler: directed vectors, multi-cycle sequences and
// random traffic checked against a cycle-stamped reference model.
module tb_sbp_pipeline_scheduler;
  import sbp_pkg::*;

  localparam int NUM_STAGES = 2;
  localparam int PL         = 2 * NUM_STAGES;
  localparam int TAG_BITS   = 8;
  localparam int MAX_BURST  = 4;
  localparam int IW         = $clog2(PL + 2);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     lkp_valid_i, lkp_ready_o;
  logic [31:0]              lkp_ip_addr_i;
  logic [TAG_BITS-1:0]      lkp_tag_i;
  logic                     upd_valid_i, upd_ready_o;
  logic [31:0]              upd_prefix_i;
  logic [5:0]               upd_len_i;
  logic [STAGE_ID_BITS-1:0] upd_stage_id_i;
  logic [LOCATION_BITS-1:0] upd_location_i;
  logic [RESULT_BITS-1:0]   upd_result_i;
  logic                     upd_sync_i;
  logic                     update_o;
  logic [31:0]              ip_addr_o;
  logic [5:0]               bit_pos_o;
  logic [STAGE_ID_BITS-1:0] stage_id_o;
  logic [LOCATION_BITS-1:0] location_o;
  logic [RESULT_BITS-1:0]   result_o;
  logic [RESULT_BITS-1:0]   tail_result_i;
  logic                     res_valid_o;
  logic [TAG_BITS-1:0]      res_tag_o;
  logic [RESULT_BITS-1:0]   res_result_o;
  logic [IW-1:0]            inflight_o;
  logic                     busy_o;

  sbp_pipeline_scheduler #(
    .NUM_STAGES    (NUM_STAGES),
    .PIPE_LATENCY  (PL),
    .TAG_BITS      (TAG_BITS),
    .MAX_UPD_BURST (MAX_BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lkp_valid_i    (lkp_valid_i),
    .lkp_ready_o    (lkp_ready_o),
    .lkp_ip_addr_i  (lkp_ip_addr_i),
    .lkp_tag_i      (lkp_tag_i),
    .upd_valid_i    (upd_valid_i),
    .upd_ready_o    (upd_ready_o),
    .upd_prefix_i   (upd_prefix_i),
    .upd_len_i      (upd_len_i),
    .upd_stage_id_i (upd_stage_id_i),
    .upd_location_i (upd_location_i),
    .upd_result_i   (upd_result_i),
    .upd_sync_i     (upd_sync_i),
    .update_o       (update_o),
    .ip_addr_o      (ip_addr_o),
    .bit_pos_o      (bit_pos_o),
    .stage_id_o     (stage_id_o),
    .location_o     (location_o),
    .result_o       (result_o),
    .tail_result_i  (tail_result_i),
    .res_valid_o    (res_valid_o),
    .res_tag_o      (res_tag_o),
    .res_result_o   (res_result_o),
    .inflight_o     (inflight_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                     rst;
    logic                     lkp_valid;
    logic [31:0]              lkp_addr;
    logic [TAG_BITS-1:0]      lkp_tag;
    logic                     upd_valid;
    logic [31:0]              upd_prefix;
    logic [5:0]               upd_len;
    logic [STAGE_ID_BITS-1:0] upd_sid;
    logic [LOCATION_BITS-1:0] upd_loc;
    logic [RESULT_BITS-1:0]   upd_res;
    logic                     upd_sync;
  } stim_t;

  typedef struct {
    logic                     lkp_v;
    logic                     upd_v;
    logic                     exp_lr;
    logic                     exp_ur;
    logic                     exp_hupd;
    logic [STAGE_ID_BITS-1:0] exp_hsid;
  } vec_t;

  typedef struct {
    int                  acc;
    logic [TAG_BITS-1:0] tag;
  } flight_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [RESULT_BITS-1:0] tail_drv;

  // Reference model state: lookups are kept with the cycle they were accepted in.
  flight_t                  fq[$];
  bit                       synced = 1'b0;
  bit                       draining;
  int                       ups;
  int                       m_infl;
  bit                       m_er_l, m_er_u;
  bit                       mdl_lg, mdl_ug;
  logic                     e_update;
  logic [31:0]              e_ip;
  logic [5:0]               e_bp;
  logic [STAGE_ID_BITS-1:0] e_sid;
  logic [LOCATION_BITS-1:0] e_loc;
  logic [RESULT_BITS-1:0]   e_res;
  logic                     e_rv;
  logic [TAG_BITS-1:0]      e_rtag;
  logic [RESULT_BITS-1:0]   e_rres;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.rst        = 1'b0;
    s.lkp_valid  = 1'b0;
    s.lkp_addr   = '0;
    s.lkp_tag    = '0;
    s.upd_valid  = 1'b0;
    s.upd_prefix = '0;
    s.upd_len    = '0;
    s.upd_sid    = '0;
    s.upd_loc    = '0;
    s.upd_res    = '0;
    s.upd_sync   = 1'b0;
    return s;
  endfunction

  // Drives one cycle of inputs after the rising edge and returns once the model
  // has evaluated that cycle.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    rst            = s.rst;
    lkp_valid_i    = s.lkp_valid;
    lkp_ip_addr_i  = s.lkp_addr;
    lkp_tag_i      = s.lkp_tag;
    upd_valid_i    = s.upd_valid;
    upd_prefix_i   = s.upd_prefix;
    upd_len_i      = s.upd_len;
    upd_stage_id_i = s.upd_sid;
    upd_location_i = s.upd_loc;
    upd_result_i   = s.upd_res;
    upd_sync_i     = s.upd_sync;
    tail_drv       = RESULT_BITS'($urandom);
    tail_result_i  = tail_drv;
    @(negedge clk);
    #1;
  endtask

  // Reference model, evaluated mid-cycle from the arbitration and tracking rules.
  always @(negedge clk) begin
    cyc = cyc + 1;
    mdl_lg = 1'b0;
    mdl_ug = 1'b0;
    if (rst) begin
      fq.delete();
      ups = 0; draining = 1'b0; synced = 1'b1;
      e_update = 1'b0; e_ip = '0; e_bp = '0; e_sid = '0; e_loc = '0; e_res = '0;
      e_rv = 1'b0; e_rtag = '0; e_rres = '0;
    end else if (synced) begin
      while (fq.size() > 0 && fq[0].acc < cyc - PL) fq.delete(0);
      m_infl = fq.size();
      checkOutput("m_inflight", 64'(inflight_o), 64'(m_infl));
      checkOutput("m_busy", 64'(busy_o), 64'((m_infl != 0) || draining));
      checkOutput("m_update", 64'(update_o), 64'(e_update));
      checkOutput("m_ip", 64'(ip_addr_o), 64'(e_ip));
      checkOutput("m_bitpos", 64'(bit_pos_o), 64'(e_bp));
      checkOutput("m_stage", 64'(stage_id_o), 64'(e_sid));
      checkOutput("m_loc", 64'(location_o), 64'(e_loc));
      checkOutput("m_result", 64'(result_o), 64'(e_res));
      checkOutput("m_res_valid", 64'(res_valid_o), 64'(e_rv));
      checkOutput("m_res_tag", 64'(res_tag_o), 64'(e_rtag));
      checkOutput("m_res_result", 64'(res_result_o), 64'(e_rres));

      if (draining || (upd_valid_i && upd_sync_i && m_infl != 0)) begin
        m_er_l = 1'b0; m_er_u = 1'b0;
      end else if (upd_valid_i && !(lkp_valid_i && ups == MAX_BURST)) begin
        m_er_l = 1'b0; m_er_u = 1'b1;
      end else begin
        m_er_l = 1'b1; m_er_u = 1'b0;
      end
      checkOutput("m_lkp_ready", 64'(lkp_ready_o), 64'(m_er_l));
      checkOutput("m_upd_ready", 64'(upd_ready_o), 64'(m_er_u));
      mdl_lg = lkp_valid_i && m_er_l;
      mdl_ug = upd_valid_i && m_er_u;

      if (draining) draining = upd_valid_i && (m_infl != 0);
      else          draining = upd_valid_i && upd_sync_i && (m_infl != 0);
      if (mdl_ug) ups = (ups < MAX_BURST) ? ups + 1 : ups;
      else        ups = 0;

      e_rv = 1'b0;
      foreach (fq[j]) begin
        if (fq[j].acc == cyc - PL) begin
          e_rv = 1'b1; e_rtag = fq[j].tag; e_rres = tail_result_i;
        end
      end

      e_update = 1'b0;
      e_sid    = '0;
      if (mdl_ug) begin
        e_update = 1'b1; e_ip = upd_prefix_i; e_bp = upd_len_i;
        e_sid = upd_stage_id_i; e_loc = upd_location_i; e_res = upd_result_i;
      end else if (mdl_lg) begin
        e_ip = lkp_ip_addr_i; e_bp = 6'd0; e_sid = 6'd1; e_loc = '0; e_res = '0;
      end
      if (mdl_lg) fq.push_back('{acc: cyc, tag: lkp_tag_i});
    end
  end

  vec_t  vecs[12];
  stim_t s;
  stim_t r;
  int    t0;
  int    last_acc;
  logic [RESULT_BITS-1:0] tail_cap;
  bit    lp, up;

  task automatic setVec(input int i, input logic lv, input logic uv, input logic lr,
                        input logic ur, input logic hu, input logic [STAGE_ID_BITS-1:0] hs);
    vecs[i] = '{lkp_v: lv, upd_v: uv, exp_lr: lr, exp_ur: ur, exp_hupd: hu, exp_hsid: hs};
  endtask

  task automatic flush();
    for (int k = 0; k < PL + 2; k++) applyStimulus(idleStim());
  endtask

  initial begin
    // Both requesters valid: four updates then one lookup; single-source rows follow.
    setVec(0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1);
    setVec(5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    setVec(8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    setVec(9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    setVec(11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1);

    rst = 1'b1; lkp_valid_i = 1'b0; upd_valid_i = 1'b0; upd_sync_i = 1'b0;
    lkp_ip_addr_i = '0; lkp_tag_i = '0; upd_prefix_i = '0; upd_len_i = '0;
    upd_stage_id_i = '0; upd_location_i = '0; upd_result_i = '0; tail_result_i = '0;

    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("rst_stage", 64'(stage_id_o), 64'(0));
    checkOutput("rst_res_valid", 64'(res_valid_o), 64'(0));
    checkOutput("rst_inflight", 64'(inflight_o), 64'(0));
    checkOutput("rst_busy", 64'(busy_o), 64'(0));

    // Single lookup: head one cycle after acceptance, result PL+1 cycles after.
    s = idleStim(); s.lkp_valid = 1'b1; s.lkp_addr = 32'h0A000001; s.lkp_tag = 8'h11;
    applyStimulus(s);
    checkOutput("lat_accept", 64'(lkp_ready_o), 64'(1));
    t0 = cyc;
    for (int k = 1; k <= PL + 2; k++) begin
      applyStimulus(idleStim());
      if (k == 1) begin
        checkOutput("lat_head_stage", 64'(stage_id_o), 64'(1));
        checkOutput("lat_head_bitpos", 64'(bit_pos_o), 64'(0));
        checkOutput("lat_head_ip", 64'(ip_addr_o), 64'(32'h0A000001));
        checkOutput("lat_inflight", 64'(inflight_o), 64'(1));
      end
      if (k == PL) tail_cap = tail_drv;
      if (k == PL + 1) begin
        checkOutput("lat_res_valid", 64'(res_valid_o), 64'(1));
        checkOutput("lat_res_tag", 64'(res_tag_o), 64'(8'h11));
        checkOutput("lat_res_result", 64'(res_result_o), 64'(tail_cap));
      end else begin
        checkOutput("lat_res_quiet", 64'(res_valid_o), 64'(0));
      end
    end

    // Update injection: never produces a result.
    s = idleStim(); s.upd_valid = 1'b1; s.upd_prefix = 32'hC0A80000; s.upd_len = 6'd16;
    s.upd_sid = 6'd3; s.upd_loc = 11'd5; s.upd_res = 24'hABCDE1;
    applyStimulus(s);
    checkOutput("upd_accept", 64'(upd_ready_o), 64'(1));
    applyStimulus(idleStim());
    checkOutput("upd_head_update", 64'(update_o), 64'(1));
    checkOutput("upd_head_ip", 64'(ip_addr_o), 64'(32'hC0A80000));
    checkOutput("upd_head_bitpos", 64'(bit_pos_o), 64'(16));
    checkOutput("upd_head_stage", 64'(stage_id_o), 64'(3));
    checkOutput("upd_head_loc", 64'(location_o), 64'(5));
    checkOutput("upd_head_result", 64'(result_o), 64'(24'hABCDE1));
    for (int k = 0; k < PL + 3; k++) begin
      applyStimulus(idleStim());
      checkOutput("upd_no_result", 64'(res_valid_o), 64'(0));
    end

    // Table-driven arbitration vectors.
    for (int i = 0; i < 12; i++) begin
      s = idleStim();
      s.lkp_valid = vecs[i].lkp_v; s.lkp_tag = 8'(i); s.lkp_addr = 32'h1000 + i;
      s.upd_valid = vecs[i].upd_v; s.upd_sid = 6'd3; s.upd_loc = 11'd5;
      s.upd_prefix = 32'h0A0B0000; s.upd_len = 6'd8;
      applyStimulus(s);
      checkOutput("vec_lkp_ready", 64'(lkp_ready_o), 64'(vecs[i].exp_lr));
      checkOutput("vec_upd_ready", 64'(upd_ready_o), 64'(vecs[i].exp_ur));
      if (i > 0) begin
        checkOutput("vec_head_update", 64'(update_o), 64'(vecs[i-1].exp_hupd));
        checkOutput("vec_head_stage", 64'(stage_id_o), 64'(vecs[i-1].exp_hsid));
      end
    end
    applyStimulus(idleStim());
    checkOutput("vec_head_update", 64'(update_o), 64'(vecs[11].exp_hupd));
    checkOutput("vec_head_stage", 64'(stage_id_o), 64'(vecs[11].exp_hsid));
    flush();

    // Sync barrier: three lookups in flight, then a barrier update with a lookup waiting.
    for (int k = 0; k < 3; k++) begin
      s = idleStim(); s.lkp_valid = 1'b1; s.lkp_tag = 8'(8'h21 + k); s.lkp_addr = 32'h2000 + k;
      applyStimulus(s);
    end
    last_acc = cyc;
    for (int k = 1; k <= PL + 3; k++) begin
      s = idleStim(); s.lkp_valid = 1'b1; s.lkp_tag = 8'h30; s.lkp_addr = 32'h3000;
      s.upd_valid = (k <= PL + 2); s.upd_sync = 1'b1; s.upd_sid = 6'd7; s.upd_loc = 11'd9;
      applyStimulus(s);
      checkOutput("drain_upd_ready", 64'(upd_ready_o), 64'(k == PL + 2));
      checkOutput("drain_lkp_ready", 64'(lkp_ready_o), 64'(k == PL + 3));
      if (k <= PL + 1) checkOutput("drain_busy", 64'(busy_o), 64'(1));
      if (k == PL) checkOutput("drain_inflight_last", 64'(inflight_o), 64'(1));
      if (k == PL + 1) checkOutput("drain_inflight_zero", 64'(inflight_o), 64'(0));
    end
    checkOutput("drain_cycle", 64'(cyc - last_acc), 64'(PL + 3));
    flush();

    // Reset with five lookups outstanding.
    for (int k = 0; k < 5; k++) begin
      s = idleStim(); s.lkp_valid = 1'b1; s.lkp_tag = 8'(8'h40 + k); s.lkp_addr = 32'h4000 + k;
      applyStimulus(s);
    end
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("mid_rst_update", 64'(update_o), 64'(0));
    checkOutput("mid_rst_ip", 64'(ip_addr_o), 64'(0));
    checkOutput("mid_rst_stage", 64'(stage_id_o), 64'(0));
    checkOutput("mid_rst_res_valid", 64'(res_valid_o), 64'(0));
    checkOutput("mid_rst_res_tag", 64'(res_tag_o), 64'(0));
    checkOutput("mid_rst_res_result", 64'(res_result_o), 64'(0));
    checkOutput("mid_rst_inflight", 64'(inflight_o), 64'(0));
    for (int k = 0; k < PL + 3; k++) begin
      applyStimulus(idleStim());
      checkOutput("mid_rst_no_stale", 64'(res_valid_o), 64'(0));
    end

    // Idle: bubbles only.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(idleStim());
      checkOutput("idle_stage", 64'(stage_id_o), 64'(0));
      checkOutput("idle_update", 64'(update_o), 64'(0));
      checkOutput("idle_busy", 64'(busy_o), 64'(0));
    end

    // Random traffic; requests are held until the model says they were accepted.
    lp = 1'b0; up = 1'b0; r = idleStim();
    for (int i = 0; i < 800; i++) begin
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1'b1; r.lkp_addr = $urandom; r.lkp_tag = 8'($urandom);
      end
      if (!up && $urandom_range(0, 3) == 0) begin
        up = 1'b1; r.upd_prefix = $urandom; r.upd_len = 6'($urandom_range(0, 32));
        r.upd_sid = 6'($urandom); r.upd_loc = 11'($urandom); r.upd_res = 24'($urandom);
        r.upd_sync = ($urandom_range(0, 3) == 0);
      end
      r.rst = (i == 400);
      r.lkp_valid = lp && !r.rst;
      r.upd_valid = up && !r.rst;
      applyStimulus(r);
      if (r.rst) begin
        lp = 1'b0; up = 1'b0;
      end
      if (mdl_lg) lp = 1'b0;
      if (mdl_ug) up = 1'b0;
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
